addm_controller_gen2: RTL

//  Parametrised multicycle controller for the adding-machine datapath (PC, IR, AC, ALU, memory).

---
 rtl/addm_controller_gen2.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/addm_controller_gen2.sv
// Multicycle controller for the adding-machine datapath: 3-bit opcode set, memory ready handshake
// with wait timeout, illegal-opcode trap and retired-instruction counter. ADDM_STEP_EN adds single-step.
module addm_controller_gen2 #(
  parameter int OPC_W    = 3,
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OPC_W-1:0] op_code,
  input  logic             ac_zero,
  input  logic             mem_rdy,
`ifdef ADDM_STEP_EN
  input  logic             step,
`endif
  output logic             rd_mem,
  output logic             wr_mem,
  output logic             ir_on_adr,
  output logic             pc_on_adr,
  output logic             ld_ir,
  output logic             ld_ac,
  output logic             ld_pc,
  output logic             inc_pc,
  output logic             clr_pc,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_ERR, S_STEPW
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000, OP_LDA = 3'b001, OP_STA = 3'b010, OP_JMP = 3'b011,
                         OP_SUB = 3'b100, OP_JZ  = 3'b101, OP_NOP = 3'b110, OP_HLT = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_phase, timeout, illegal;

  // Only FETCH and the memory-touching EXEC opcodes wait on mem_rdy.
  assign mem_phase = (state_q == S_FETCH) ||
                     ((state_q == S_EXEC) && ((op_q == OP_LDA) || (op_q == OP_STA)));
  assign timeout   = mem_phase && !mem_rdy && (wait_q == 8'(WAIT_MAX - 1));
  assign illegal   = |(op_code >> 3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RST;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // wait_d defaults to zero so any state change or completion clears the stall count.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    cnt_d   = cnt_q;
    case (state_q)
      S_RST:    state_d = S_FETCH;
      S_FETCH: begin
        if (mem_rdy)      state_d = S_DECODE;
        else if (timeout) state_d = S_ERR;
        else              wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        op_d    = op_code[2:0];
        state_d = illegal ? S_ERR : S_EXEC;
      end
      S_EXEC: begin
        if (op_q == OP_HLT) begin
          state_d = S_HALT;
        end else if (mem_phase && !mem_rdy) begin
          if (timeout) state_d = S_ERR;
          else         wait_d  = wait_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
`ifdef ADDM_STEP_EN
          state_d = S_STEPW;
`else
          state_d = S_FETCH;
`endif
        end
      end
`ifdef ADDM_STEP_EN
      S_STEPW:  if (step) state_d = S_FETCH;
`endif
      default:  state_d = state_q;
    endcase
  end

  always_comb begin
    rd_mem    = 1'b0;
    wr_mem    = 1'b0;
    ir_on_adr = 1'b0;
    pc_on_adr = 1'b0;
    ld_ir     = 1'b0;
    ld_ac     = 1'b0;
    ld_pc     = 1'b0;
    inc_pc    = 1'b0;
    clr_pc    = 1'b0;
    alu_op    = 2'b00;
    halted    = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_RST:   clr_pc = 1'b1;
      S_FETCH: begin
        pc_on_adr = 1'b1;
        rd_mem    = 1'b1;
        ld_ir     = mem_rdy;
        inc_pc    = mem_rdy;
      end
      S_EXEC: begin
        case (op_q)
          OP_ADD: begin alu_op = 2'b01; ld_ac = 1'b1; end
          OP_LDA: begin ir_on_adr = 1'b1; rd_mem = 1'b1; ld_ac = mem_rdy; end
          OP_STA: begin ir_on_adr = 1'b1; wr_mem = 1'b1; end
          OP_JMP: ld_pc = 1'b1;
          OP_SUB: begin alu_op = 2'b10; ld_ac = 1'b1; end
          OP_JZ:  ld_pc = ac_zero;
          default: ;
        endcase
      end
      S_HALT:  halted = 1'b1;
      S_ERR:   err    = 1'b1;
      default: ;
    endcase
  end

  assign instr_cnt   = cnt_q;
  assign dbg_state_o = state_q;

endmodule
